// File: rtl/fb_pkg.sv
// Shared types and helpers for the ping-pong frame buffer.
// Bank states, writer/reader FSM states, width helpers.
package fb_pkg;

  typedef enum logic [2:0] {
    BK_EMPTY,
    BK_FILLING,
    BK_FULL,
    BK_SENDING,
    BK_SHOWN
  } bank_t;

  typedef enum logic {
    W_IDLE,
    W_BURST
  } wr_st_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LOAD,
    R_BURST
  } rd_st_t;

  function automatic int aw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int dw_of(input int ch, input int pw);
    return ch * pw;
  endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM, one write port, one registered read port.
// Ports: clk, xrst (clears read register), we/waddr/wdata, re/raddr/rdata.
module fb_dpram #(
  parameter int AW = 5,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Full 2**AW depth: {bank, addr} addressing leaves holes
  // when the frame size is not a power of two.
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/framebuf_pingpong.sv
// Double-buffered frame buffer: receive frame N+1 while sending N.
// Ports: clk, xrst, pixel_in/rcv_req/rcv_ack (rx), pixel_out/snd_req/snd_ack (tx), rcv_err, bank_full.
module framebuf_pingpong
  import fb_pkg::*;
#(
  parameter int PIXEL_NUM = 16384,
  parameter int CH        = 3,
  parameter int PW        = 8,
  parameter int REPEAT    = 0,
  localparam int AW       = aw_of(PIXEL_NUM),
  localparam int DW       = dw_of(CH, PW)
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic [DW-1:0] pixel_in,
  output logic          rcv_req,
  input  logic          rcv_ack,
  output logic [DW-1:0] pixel_out,
  input  logic          snd_req,
  output logic          snd_ack,
  output logic          rcv_err,
  output logic [1:0]    bank_full
);

  localparam logic [AW-1:0] LAST = AW'(PIXEL_NUM - 1);

  bank_t   bank     [2];
  bank_t   bank_nxt [2];
  wr_st_t  w_st, w_nxt;
  rd_st_t  r_st, r_nxt;
  logic    wbank, wbank_nxt;
  logic    rbank, rbank_nxt;
  logic    newest, newest_nxt;
  logic [AW-1:0] waddr, waddr_nxt;
  logic [AW-1:0] raddr, raddr_nxt;
  logic    err_nxt, rreq_nxt;

  logic full0, full1, shown0, shown1;
  logic rd_ok, rd_pick, wr_pick;

  logic          mem_we, mem_re;
  logic [AW:0]   mem_wa, mem_ra;

  assign full0  = (bank[0] == BK_FULL);
  assign full1  = (bank[1] == BK_FULL);
  assign shown0 = (bank[0] == BK_SHOWN);
  assign shown1 = (bank[1] == BK_SHOWN);

  assign wr_pick = (bank[0] == BK_EMPTY) ? 1'b0 : 1'b1;

  // Oldest FULL first; a SHOWN bank only when nothing is FULL.
  always_comb begin
    rd_ok   = 1'b0;
    rd_pick = 1'b0;
    unique case (1'b1)
      full0 && full1: begin
        rd_ok   = 1'b1;
        rd_pick = ~newest;
      end
      full0 && !full1: begin
        rd_ok   = 1'b1;
        rd_pick = 1'b0;
      end
      !full0 && full1: begin
        rd_ok   = 1'b1;
        rd_pick = 1'b1;
      end
      (REPEAT != 0) && !full0 && !full1 && shown0: begin
        rd_ok   = 1'b1;
        rd_pick = 1'b0;
      end
      (REPEAT != 0) && !full0 && !full1 && shown1: begin
        rd_ok   = 1'b1;
        rd_pick = 1'b1;
      end
      default: begin
        rd_ok   = 1'b0;
        rd_pick = 1'b0;
      end
    endcase
  end

  always_comb begin
    bank_nxt   = bank;
    w_nxt      = w_st;
    r_nxt      = r_st;
    wbank_nxt  = wbank;
    rbank_nxt  = rbank;
    newest_nxt = newest;
    waddr_nxt  = waddr;
    raddr_nxt  = raddr;
    err_nxt    = 1'b0;

    unique case (r_st)
      R_IDLE: begin
        if (snd_req && rd_ok) begin
          rbank_nxt         = rd_pick;
          bank_nxt[rd_pick] = BK_SENDING;
          raddr_nxt         = '0;
          r_nxt             = R_LOAD;
        end
      end
      R_LOAD: begin
        raddr_nxt = AW'(1);
        r_nxt     = R_BURST;
      end
      R_BURST: begin
        // raddr runs one ahead of the output, so 0 marks the last pixel
        if (raddr == '0) begin
          r_nxt = R_IDLE;
          if (REPEAT != 0) begin
            bank_nxt[rbank] = BK_SHOWN;
            if (bank[~rbank] == BK_SHOWN)
              bank_nxt[~rbank] = BK_EMPTY;
          end else begin
            bank_nxt[rbank] = BK_EMPTY;
          end
        end else begin
          raddr_nxt = (raddr == LAST) ? '0 : raddr + AW'(1);
        end
      end
      default: r_nxt = R_IDLE;
    endcase

    unique case (w_st)
      W_IDLE: begin
        if (rcv_ack) begin
          if (rcv_req) begin
            wbank_nxt         = wr_pick;
            bank_nxt[wr_pick] = BK_FILLING;
            waddr_nxt         = AW'(1);
            w_nxt             = W_BURST;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      W_BURST: begin
        if (!rcv_ack) begin
          bank_nxt[wbank] = BK_EMPTY;
          waddr_nxt       = '0;
          err_nxt         = 1'b1;
          w_nxt           = W_IDLE;
        end else if (waddr == LAST) begin
          bank_nxt[wbank] = BK_FULL;
          newest_nxt      = wbank;
          waddr_nxt       = '0;
          w_nxt           = W_IDLE;
          // A fresh frame retires the repeat candidate
          if ((REPEAT != 0) && (bank_nxt[~wbank] == BK_SHOWN))
            bank_nxt[~wbank] = BK_EMPTY;
        end else begin
          waddr_nxt = waddr + AW'(1);
        end
      end
      default: w_nxt = W_IDLE;
    endcase

    rreq_nxt = (w_nxt == W_IDLE) &&
               ((bank_nxt[0] == BK_EMPTY) ||
                (bank_nxt[1] == BK_EMPTY));
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      bank[0] <= BK_EMPTY;
      bank[1] <= BK_EMPTY;
      w_st    <= W_IDLE;
      r_st    <= R_IDLE;
      wbank   <= 1'b0;
      rbank   <= 1'b0;
      newest  <= 1'b0;
      waddr   <= '0;
      raddr   <= '0;
      rcv_req <= 1'b0;
      rcv_err <= 1'b0;
      snd_ack <= 1'b0;
    end else begin
      bank[0] <= bank_nxt[0];
      bank[1] <= bank_nxt[1];
      w_st    <= w_nxt;
      r_st    <= r_nxt;
      wbank   <= wbank_nxt;
      rbank   <= rbank_nxt;
      newest  <= newest_nxt;
      waddr   <= waddr_nxt;
      raddr   <= raddr_nxt;
      rcv_req <= rreq_nxt;
      rcv_err <= err_nxt;
      snd_ack <= (r_nxt == R_BURST);
    end
  end

  assign bank_full = {full1, full0};

  assign mem_we = rcv_ack &&
                  (((w_st == W_IDLE) && rcv_req) ||
                   (w_st == W_BURST));
  assign mem_wa = (w_st == W_IDLE) ?
                  {wr_pick, {AW{1'b0}}} :
                  {wbank, waddr};
  // No read on the closing edge so pixel_out holds the last pixel
  assign mem_re = (r_st == R_LOAD) ||
                  ((r_st == R_BURST) && (raddr != '0));
  assign mem_ra = {rbank, raddr};

  fb_dpram #(
    .AW (AW + 1),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .xrst  (xrst),
    .we    (mem_we),
    .waddr (mem_wa),
    .wdata (pixel_in),
    .re    (mem_re),
    .raddr (mem_ra),
    .rdata (pixel_out)
  );

endmodule

// File: tb/tb_framebuf_pingpong.sv
// Directed bench for framebuf_pingpong, 16-pixel RGB888 frames.
// dut0 runs REPEAT=0, dut1 runs REPEAT=1 on shared inputs.
module tb_framebuf_pingpong;

  localparam int N = 16;

  logic        clk      = 1'b0;
  logic        xrst     = 1'b0;
  logic [23:0] pixel_in = '0;
  logic        rcv_ack  = 1'b0;
  logic        snd_req  = 1'b0;
  logic        sel      = 1'b0;

  logic        rcv_req0, snd_ack0, rcv_err0;
  logic [23:0] pixel_out0;
  logic [1:0]  bank_full0;
  logic        rcv_req1, snd_ack1, rcv_err1;
  logic [23:0] pixel_out1;
  logic [1:0]  bank_full1;

  logic        rreq, sack, rerr;
  logic [23:0] pout;
  logic [1:0]  bfull;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign rreq  = sel ? rcv_req1   : rcv_req0;
  assign sack  = sel ? snd_ack1   : snd_ack0;
  assign rerr  = sel ? rcv_err1   : rcv_err0;
  assign pout  = sel ? pixel_out1 : pixel_out0;
  assign bfull = sel ? bank_full1 : bank_full0;

  framebuf_pingpong #(
    .PIXEL_NUM (N), .CH (3), .PW (8), .REPEAT (0)
  ) dut0 (
    .clk       (clk),
    .xrst      (xrst),
    .pixel_in  (pixel_in),
    .rcv_req   (rcv_req0),
    .rcv_ack   (rcv_ack),
    .pixel_out (pixel_out0),
    .snd_req   (snd_req),
    .snd_ack   (snd_ack0),
    .rcv_err   (rcv_err0),
    .bank_full (bank_full0)
  );

  framebuf_pingpong #(
    .PIXEL_NUM (N), .CH (3), .PW (8), .REPEAT (1)
  ) dut1 (
    .clk       (clk),
    .xrst      (xrst),
    .pixel_in  (pixel_in),
    .rcv_req   (rcv_req1),
    .rcv_ack   (rcv_ack),
    .pixel_out (pixel_out1),
    .snd_req   (snd_req),
    .snd_ack   (snd_ack1),
    .rcv_err   (rcv_err1),
    .bank_full (bank_full1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pix(input logic [7:0] t,
                                      input int i);
    logic [7:0] b;
    b = i[7:0];
    return {(t == 8'h00) ? b : t, b, b};
  endfunction

  task automatic wr_frame(input logic [7:0] t);
    int c = 0;
    while (!rreq && c < 64) begin
      tick();
      c++;
    end
    chk($sformatf("wr_req_%h", t), 32'(rreq), 32'd1);
    for (int i = 0; i < N; i++) begin
      rcv_ack  = 1'b1;
      pixel_in = pix(t, i);
      tick();
    end
    rcv_ack = 1'b0;
  endtask

  task automatic rd_frame(input logic [7:0] t);
    snd_req = 1'b1;
    tick();
    snd_req = 1'b0;
    chk($sformatf("rd_load_%h", t), 32'(sack), 32'd0);
    tick();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rd_ack_%h_%0d", t, k), 32'(sack), 32'd1);
      chk($sformatf("rd_pix_%h_%0d", t, k), 32'(pout),
          32'(pix(t, k)));
      tick();
    end
    chk($sformatf("rd_end_%h", t), 32'(sack), 32'd0);
    chk($sformatf("rd_hold_%h", t), 32'(pout),
        32'(pix(t, N - 1)));
  endtask

  initial begin
    // T1a: reset state
    tick();
    tick();
    chk("rst_rreq",  32'(rcv_req0),   32'd0);
    chk("rst_sack",  32'(snd_ack0),   32'd0);
    chk("rst_pout",  32'(pixel_out0), 32'd0);
    chk("rst_bfull", 32'(bank_full0), 32'd0);
    chk("rst_rerr",  32'(rcv_err0),   32'd0);
    xrst = 1'b1;
    tick();
    chk("rel_rreq",  32'(rcv_req0),   32'd1);

    // T2: single frame
    wr_frame(8'h00);
    chk("t2_bfull_w", 32'(bank_full0), 32'd1);
    chk("t2_rerr",    32'(rcv_err0),   32'd0);
    rd_frame(8'h00);
    chk("t2_bfull_r", 32'(bank_full0), 32'd0);

    // T3: ping-pong, B written while A is sent
    wr_frame(8'h11);
    fork
      rd_frame(8'h11);
      begin
        tick();
        tick();
        chk("t3_rreq_send", 32'(rcv_req0), 32'd1);
        wr_frame(8'h22);
      end
    join
    chk("t3_bfull", 32'(bank_full0), 32'd2);
    rd_frame(8'h22);
    chk("t3_bfull_r", 32'(bank_full0), 32'd0);

    // T4: both banks full, stray strobe
    wr_frame(8'h33);
    wr_frame(8'h44);
    chk("t4_bfull", 32'(bank_full0), 32'd3);
    chk("t4_rreq",  32'(rcv_req0),   32'd0);
    rcv_ack  = 1'b1;
    pixel_in = 24'hDEAD00;
    tick();
    rcv_ack  = 1'b0;
    chk("t4_rerr_hi", 32'(rcv_err0), 32'd1);
    tick();
    chk("t4_rerr_lo", 32'(rcv_err0), 32'd0);
    chk("t4_bfull2",  32'(bank_full0), 32'd3);
    rd_frame(8'h33);
    chk("t4_bfull_r", 32'(bank_full0), 32'd2);

    // T1b: reset while sending bank 1 and filling bank 0
    snd_req  = 1'b1;
    rcv_ack  = 1'b1;
    pixel_in = 24'hAA0000;
    tick();
    snd_req = 1'b0;
    for (int i = 1; i < 5; i++) begin
      pixel_in = 24'hAA0000 | 24'(i);
      tick();
    end
    chk("t1_mid_sack", 32'(snd_ack0),   32'd1);
    chk("t1_mid_pix",  32'(pixel_out0), 32'(pix(8'h44, 3)));
    xrst = 1'b0;
    #1;
    rcv_ack = 1'b0;
    chk("t1_rst_rreq",  32'(rcv_req0),   32'd0);
    chk("t1_rst_sack",  32'(snd_ack0),   32'd0);
    chk("t1_rst_pout",  32'(pixel_out0), 32'd0);
    chk("t1_rst_bfull", 32'(bank_full0), 32'd0);
    tick();
    xrst = 1'b1;
    tick();
    chk("t1_rel_rreq", 32'(rcv_req0), 32'd1);
    snd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t1_nodata_%0d", i), 32'(snd_ack0), 32'd0);
    end
    snd_req = 1'b0;

    // T5: abort after 7 pixels
    for (int i = 0; i < 7; i++) begin
      rcv_ack  = 1'b1;
      pixel_in = pix(8'h55, i);
      tick();
    end
    rcv_ack = 1'b0;
    tick();
    chk("t5_rerr_hi", 32'(rcv_err0),   32'd1);
    chk("t5_bfull",   32'(bank_full0), 32'd0);
    chk("t5_rreq",    32'(rcv_req0),   32'd1);
    tick();
    chk("t5_rerr_lo", 32'(rcv_err0),   32'd0);
    wr_frame(8'h66);
    chk("t5_bfull_w", 32'(bank_full0), 32'd1);
    rd_frame(8'h66);

    // T6: repeat mode on dut1
    sel  = 1'b1;
    xrst = 1'b0;
    tick();
    tick();
    xrst = 1'b1;
    tick();
    wr_frame(8'h77);
    rd_frame(8'h77);
    chk("t6_bfull_a", 32'(bfull), 32'd0);
    chk("t6_rreq_a",  32'(rreq),  32'd1);
    rd_frame(8'h77);
    wr_frame(8'h88);
    chk("t6_bfull_b", 32'(bfull), 32'd2);
    chk("t6_rreq_b",  32'(rreq),  32'd1);
    chk("t6_rerr",    32'(rerr),  32'd0);
    rd_frame(8'h88);
    chk("t6_bfull_r", 32'(bfull), 32'd0);
    rd_frame(8'h88);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
